// File: rtl/key_event_poller.sv
// key_event_poller
//   Avalon-MM master for the key PIO. At a fixed interval it reads the PIO
//   edge-capture register (addr 3). If any key edge was captured, it clears
//   the register and queues a timestamped event in a small FIFO.
//
//   Optional feature macro: KEY_POLL_LEVEL_EN
//     defined   : also read the PIO data register (addr 0) after the clear
//                 and store the key levels with each event.
//     undefined : no level read and no level storage; evt_level_o reads 0.
//
// Ports
//   clk_i, reset_n_i        clock, async active-low reset
//   poll_en_i               enable periodic polling
//   avm_*                   Avalon-MM master towards the PIO (readdata 1-cycle latency)
//   evt_valid_o/evt_ready_i FIFO head handshake (pop on valid & ready)
//   evt_keys_o/level_o/ts_o head event payload
//   ovf_o, ovf_clr_i        sticky drop flag and its clear (a drop wins)
//   busy_o                  transaction in progress
module key_event_poller #(
   parameter int NUM_KEYS   = 2,
   parameter int POLL_DIV   = 50000,
   parameter int FIFO_DEPTH = 4,
   parameter int TS_W       = 16
) (
   input  logic                clk_i,
   input  logic                reset_n_i,
   input  logic                poll_en_i,
   output logic [1:0]          avm_address_o,
   output logic                avm_chipselect_o,
   output logic                avm_write_n_o,
   output logic [31:0]         avm_writedata_o,
   input  logic [31:0]         avm_readdata_i,
   output logic                evt_valid_o,
   input  logic                evt_ready_i,
   output logic [NUM_KEYS-1:0] evt_keys_o,
   output logic [NUM_KEYS-1:0] evt_level_o,
   output logic [TS_W-1:0]     evt_ts_o,
   output logic                ovf_o,
   input  logic                ovf_clr_i,
   output logic                busy_o
);

   localparam int TMR_W = $clog2(POLL_DIV);
   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam logic [TMR_W-1:0] RELOAD = TMR_W'(POLL_DIV - 1);

`ifdef KEY_POLL_LEVEL_EN
   typedef enum logic [2:0] {S_IDLE, S_RD_EDGE, S_RD_WAIT, S_CLR,
                             S_RD_LVL, S_LVL_WAIT, S_PUSH} state_e;
`else
   typedef enum logic [2:0] {S_IDLE, S_RD_EDGE, S_RD_WAIT, S_CLR, S_PUSH} state_e;
`endif

   state_e              state_q, state_d;
   logic [TMR_W-1:0]    timer_q, timer_d;
   logic                poll_tick;
   logic [TS_W-1:0]     ts_q;
   logic [1:0]          addr_q, addr_d;
   logic                cs_q, cs_d, wn_q, wn_d;
   logic [NUM_KEYS-1:0] edges_q;
   logic [TS_W-1:0]     tsamp_q;
   logic [NUM_KEYS-1:0] rd_keys;
   logic                unused_rd;

   logic [FIFO_DEPTH-1:0][NUM_KEYS-1:0] keys_mem_q;
   logic [FIFO_DEPTH-1:0][TS_W-1:0]     ts_mem_q;
   logic [PTR_W-1:0]    wr_ptr_q, rd_ptr_q;
   logic [CNT_W-1:0]    count_q, count_d;
   logic                push, pop, push_ok, drop;
   logic                ovf_q;

   assign rd_keys   = avm_readdata_i[NUM_KEYS-1:0];
   assign unused_rd = ^avm_readdata_i;

   // The timer runs in every state while enabled so that poll starts stay
   // exactly POLL_DIV cycles apart; a transaction is always shorter than
   // POLL_DIV, so the FSM is back in IDLE when the timer expires.
   always_comb begin
      timer_d   = timer_q;
      poll_tick = 1'b0;
      if (!poll_en_i) begin
         timer_d = RELOAD;
      end else if (timer_q == '0) begin
         timer_d   = RELOAD;
         poll_tick = 1'b1;
      end else begin
         timer_d = timer_q - TMR_W'(1);
      end
   end

   // Next state
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:    if (poll_tick) state_d = S_RD_EDGE;
         S_RD_EDGE: state_d = S_RD_WAIT;
         S_RD_WAIT: state_d = (rd_keys == '0) ? S_IDLE : S_CLR;
`ifdef KEY_POLL_LEVEL_EN
         S_CLR:      state_d = S_RD_LVL;
         S_RD_LVL:   state_d = S_LVL_WAIT;
         S_LVL_WAIT: state_d = S_PUSH;
`else
         S_CLR:      state_d = S_PUSH;
`endif
         S_PUSH:    state_d = S_IDLE;
         default:   state_d = S_IDLE;
      endcase
   end

   // Avalon outputs are decoded from the next state and registered, so they
   // are glitch-free and valid for the whole cycle of the state they belong to.
   always_comb begin
      addr_d = 2'd0;
      cs_d   = 1'b0;
      wn_d   = 1'b1;
      case (state_d)
         S_RD_EDGE: begin addr_d = 2'd3; cs_d = 1'b1; end
         S_RD_WAIT: addr_d = 2'd3;
         S_CLR:     begin addr_d = 2'd3; cs_d = 1'b1; wn_d = 1'b0; end
`ifdef KEY_POLL_LEVEL_EN
         S_RD_LVL:  cs_d = 1'b1;
`endif
         default: ;
      endcase
   end

   // FIFO control: a push into a full FIFO is only accepted if a pop frees
   // the head in the same cycle.
   assign push    = (state_q == S_PUSH);
   assign pop     = evt_ready_i && (count_q != '0);
   assign push_ok = push && ((count_q < CNT_W'(FIFO_DEPTH)) || pop);
   assign drop    = push && !push_ok;

   always_comb begin
      count_d = count_q;
      case ({push_ok, pop})
         2'b10:   count_d = count_q + CNT_W'(1);
         2'b01:   count_d = count_q - CNT_W'(1);
         default: ;
      endcase
   end

   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         state_q  <= S_IDLE;
         timer_q  <= RELOAD;
         ts_q     <= '0;
         addr_q   <= 2'd0;
         cs_q     <= 1'b0;
         wn_q     <= 1'b1;
         edges_q  <= '0;
         tsamp_q  <= '0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         ovf_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         timer_q <= timer_d;
         ts_q    <= ts_q + TS_W'(1);
         addr_q  <= addr_d;
         cs_q    <= cs_d;
         wn_q    <= wn_d;
         if (state_q == S_RD_WAIT) begin
            edges_q <= rd_keys;
            tsamp_q <= ts_q;
         end
         if (push_ok) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
         if (pop)     rd_ptr_q <= rd_ptr_q + PTR_W'(1);
         count_q <= count_d;
         // A drop in the same cycle as a clear leaves the flag set.
         if (drop)           ovf_q <= 1'b1;
         else if (ovf_clr_i) ovf_q <= 1'b0;
      end
   end

   // Event storage needs no reset; entries are only visible once counted.
   always_ff @(posedge clk_i) begin
      if (push_ok) begin
         keys_mem_q[wr_ptr_q] <= edges_q;
         ts_mem_q[wr_ptr_q]   <= tsamp_q;
      end
   end

`ifdef KEY_POLL_LEVEL_EN
   logic [NUM_KEYS-1:0]                 lvl_q;
   logic [FIFO_DEPTH-1:0][NUM_KEYS-1:0] lvl_mem_q;

   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i)                 lvl_q <= '0;
      else if (state_q == S_LVL_WAIT) lvl_q <= rd_keys;
   end

   always_ff @(posedge clk_i) begin
      if (push_ok) lvl_mem_q[wr_ptr_q] <= lvl_q;
   end

   assign evt_level_o = lvl_mem_q[rd_ptr_q];
`else
   assign evt_level_o = '0;
`endif

   assign avm_address_o    = addr_q;
   assign avm_chipselect_o = cs_q;
   assign avm_write_n_o    = wn_q;
   assign avm_writedata_o  = 32'd0;
   assign evt_valid_o      = (count_q != '0);
   assign evt_keys_o       = keys_mem_q[rd_ptr_q];
   assign evt_ts_o         = ts_mem_q[rd_ptr_q];
   assign ovf_o            = ovf_q;
   assign busy_o           = (state_q != S_IDLE);

endmodule
